// File: rtl/wishbone_dma_engine.sv
// Memory-to-memory DMA engine: Wishbone master copying len words from src to dst,
// one read followed by one write per word, with per-access timeout and error abort.
module wishbone_dma_engine #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_src_addr,
  input  logic [ADDR_WIDTH-1:0]   i_dst_addr,
  input  logic [LEN_WIDTH-1:0]    i_len,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [ADDR_WIDTH-1:0]   o_wb_adr,
  output logic [DATA_WIDTH-1:0]   o_wb_dat_w,
  output logic [DATA_WIDTH/8-1:0] o_wb_sel,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_err,
  input  logic [DATA_WIDTH-1:0]   i_wb_dat_r,
  output logic [2:0]              o_state,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [LEN_WIDTH-1:0]    o_words_done
);

  localparam int unsigned SEL_W  = DATA_WIDTH / 8;
  localparam int unsigned STRIDE = DATA_WIDTH / 8;
  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [LEN_WIDTH-1:0]  words_d;
  logic [ADDR_WIDTH-1:0] adr_d;
  logic [DATA_WIDTH-1:0] dat_w_d;
  logic [SEL_W-1:0]      sel_d;
  logic                  cyc_d, we_d, done_d, err_d, busy_d;

  logic in_rd, in_wr, live, acc_ack, acc_err, tmo_hit, last_word, req_d, req_entry;

  // A REQ state entered right after a completed access holds cyc low for one
  // cycle (the grant-release gap); the bus is only "live" while cyc is high.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    buf_d     = buf_q;
    tmo_d     = tmo_q;
    words_d   = o_words_done;
    adr_d     = o_wb_adr;
    dat_w_d   = o_wb_dat_w;
    err_d     = o_err;

    in_rd     = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
    in_wr     = (state_q == S_WR_REQ) || (state_q == S_WR_WAIT);
    live      = (in_rd || in_wr) && o_wb_cyc;
    acc_err   = live && i_wb_err;
    acc_ack   = live && i_wb_ack && !i_wb_err;
    tmo_hit   = live && !i_wb_ack && !i_wb_err &&
                (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    last_word = (o_words_done + LEN_WIDTH'(1)) == len_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_SETUP;
          src_d   = i_src_addr;
          dst_d   = i_dst_addr;
          len_d   = i_len;
          err_d   = 1'b0;
          words_d = '0;
        end
      end
      S_SETUP: state_d = (len_q == '0) ? S_DONE : S_RD_REQ;
      S_RD_REQ, S_RD_WAIT: begin
        if (acc_err || tmo_hit) begin
          state_d = S_ERROR;
        end else if (acc_ack) begin
          state_d = S_WR_REQ;
          buf_d   = i_wb_dat_r;
        end else if (live && (state_q == S_RD_REQ)) begin
          state_d = S_RD_WAIT;
        end
      end
      S_WR_REQ, S_WR_WAIT: begin
        if (acc_err || tmo_hit) begin
          state_d = S_ERROR;
        end else if (acc_ack) begin
          src_d   = src_q + ADDR_WIDTH'(STRIDE);
          dst_d   = dst_q + ADDR_WIDTH'(STRIDE);
          words_d = o_words_done + LEN_WIDTH'(1);
          state_d = last_word ? S_DONE : S_RD_REQ;
        end else if (live && (state_q == S_WR_REQ)) begin
          state_d = S_WR_WAIT;
        end
      end
      S_DONE, S_ERROR: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase

    req_d     = (state_d == S_RD_REQ) || (state_d == S_RD_WAIT) ||
                (state_d == S_WR_REQ) || (state_d == S_WR_WAIT);
    req_entry = ((state_d == S_RD_REQ) || (state_d == S_WR_REQ)) && (state_d != state_q);
    cyc_d     = req_d && !(acc_ack || acc_err);
    we_d      = cyc_d && ((state_d == S_WR_REQ) || (state_d == S_WR_WAIT));
    sel_d     = cyc_d ? {SEL_W{1'b1}} : '0;
    if (cyc_d) begin
      adr_d = we_d ? dst_q : src_q;
    end
    if (we_d) begin
      dat_w_d = buf_q;
    end

    if (req_entry) begin
      tmo_d = '0;
    end else if (live) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (state_d == S_ERROR) begin
      err_d = 1'b1;
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; async reset drops the bus immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      buf_q        <= '0;
      tmo_q        <= '0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_adr     <= '0;
      o_wb_dat_w   <= '0;
      o_wb_sel     <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_words_done <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      buf_q        <= buf_d;
      tmo_q        <= tmo_d;
      o_wb_cyc     <= cyc_d;
      o_wb_stb     <= cyc_d;
      o_wb_we      <= we_d;
      o_wb_adr     <= adr_d;
      o_wb_dat_w   <= dat_w_d;
      o_wb_sel     <= sel_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_err        <= err_d;
      o_words_done <= words_d;
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_wishbone_dma_engine.sv
// Directed bench for wishbone_dma_engine: a pattern-memory slave with configurable
// wait/err/no-ack behaviour and a scoreboard of expected bus accesses.
module tb_wishbone_dma_engine;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 16;
  localparam int unsigned TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   src_addr, dst_addr;
  logic [LW-1:0]   len;
  logic            cyc, stb, we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w, dat_r;
  logic [DW/8-1:0] sel;
  logic            ack, err;
  logic [2:0]      state;
  logic            busy, done, err_flag;
  logic [LW-1:0]   words_done;

  always #5 clk = ~clk;

  wishbone_dma_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_len(len),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_adr(adr),
    .o_wb_dat_w(dat_w), .o_wb_sel(sel),
    .i_wb_ack(ack), .i_wb_err(err), .i_wb_dat_r(dat_r),
    .o_state(state), .o_busy(busy), .o_done(done), .o_err(err_flag),
    .o_words_done(words_done)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Slave configuration, driven by the stimulus block
  int unsigned   wait_n = 0;
  bit            no_ack = 1'b0;
  bit            err_en = 1'b0;
  logic [LW-1:0] err_at = '0;
  int unsigned   wcnt;
  logic          resp;

  // Monitor state
  int          done_cnt, cyc_cnt, st7_cnt, err7_cnt;
  logic [63:0] trace_v;
  logic [2:0]  last_state;
  bit          prev_complete;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign resp  = cyc && stb && !no_ack && (wcnt == wait_n);
  assign ack   = resp;
  assign err   = resp && err_en && we && (words_done == err_at);
  assign dat_r = pattern(adr);

  always @(posedge clk or posedge rst) begin
    if (rst)                    wcnt <= 0;
    else if (!(cyc && stb) || resp) wcnt <= 0;
    else                        wcnt <= wcnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_test();
    done_cnt      = 0;
    cyc_cnt       = 0;
    st7_cnt       = 0;
    err7_cnt      = 0;
    trace_v       = '0;
    last_state    = 3'd0;
    prev_complete = 1'b0;
  endtask

  // Advance one cycle; all monitoring happens at the falling edge.
  task automatic step();
    txn_t e;
    @(negedge clk);
    if (rst) begin
      prev_complete = 1'b0;
    end else begin
      if (state != last_state) begin
        trace_v    = {trace_v[59:0], 1'b0, state};
        last_state = state;
      end
      if (cyc) cyc_cnt++;
      if (done) done_cnt++;
      if (state == 3'd7) begin
        st7_cnt++;
        if (err_flag) err7_cnt++;
      end
      if (prev_complete) check("cyc_gap", 64'(cyc), 64'd0);
      if (cyc && (ack || err)) begin
        check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_we", 64'(we), 64'(e.we));
          check("sb_adr", 64'(adr), 64'(e.adr));
          check("sb_sel", 64'(sel), 64'hF);
          if (e.we) check("sb_dat", 64'(dat_w), 64'(e.dat));
        end
      end
      prev_complete = cyc && stb && (ack || err);
    end
  endtask

  task automatic push_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{1'b0, s + AW'(4 * i), '0});
      exp_q.push_back('{1'b1, d + AW'(4 * i), pattern(s + AW'(4 * i))});
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
    src_addr = s;
    dst_addr = d;
    len      = n;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    for (k = 0; k < budget; k++) begin
      step();
      if (state == 3'd0 && !busy) break;
    end
    check({tag, "_idle"}, 64'(k < budget), 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    begin_test();
    repeat (2) @(negedge clk);
    check("rst_state", 64'(state), 64'd0);
    check("rst_cyc", 64'({cyc, stb, we}), 64'd0);
    check("rst_adr", 64'(adr), 64'd0);
    check("rst_dat", 64'(dat_w), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_flags", 64'({busy, done, err_flag}), 64'd0);
    check("rst_words", 64'(words_done), 64'd0);
    rst = 1'b0;
    step();

    // len=4 with one wait cycle per access
    begin_test();
    wait_n = 1;
    push_copy(32'h100, 32'h200, 4);
    pulse_start(32'h100, 32'h200, 16'd4);
    wait_idle(200, "len4");
    check("len4_done", 64'(done_cnt), 64'd1);
    check("len4_words", 64'(words_done), 64'd4);
    check("len4_err", 64'(err_flag), 64'd0);
    check("len4_sb_empty", 64'(exp_q.size()), 64'd0);

    // len=0: SETUP straight to DONE, no bus activity
    begin_test();
    pulse_start(32'h1000, 32'h2000, 16'd0);
    wait_idle(20, "len0");
    check("len0_trace", trace_v, 64'h160);
    check("len0_cyc", 64'(cyc_cnt), 64'd0);
    check("len0_done", 64'(done_cnt), 64'd1);
    check("len0_err", 64'(err_flag), 64'd0);
    check("len0_words", 64'(words_done), 64'd0);

    // err (together with ack) on the 2nd write of len=3
    begin_test();
    wait_n = 1; err_en = 1'b1; err_at = 16'd1;
    push_copy(32'h300, 32'h380, 2);
    pulse_start(32'h300, 32'h380, 16'd3);
    wait_idle(200, "werr");
    check("werr_trace", trace_v, 64'h12345234570);
    check("werr_st7", 64'(st7_cnt), 64'd1);
    check("werr_err_in7", 64'(err7_cnt), 64'd1);
    check("werr_err", 64'(err_flag), 64'd1);
    check("werr_words", 64'(words_done), 64'd1);
    check("werr_done", 64'(done_cnt), 64'd0);
    check("werr_sb_empty", 64'(exp_q.size()), 64'd0);
    err_en = 1'b0;

    // slave never responds: abort after TMO cycles of cyc
    begin_test();
    no_ack = 1'b1;
    pulse_start(32'h700, 32'h780, 16'd2);
    wait_idle(100, "tmo");
    check("tmo_cyc_cycles", 64'(cyc_cnt), 64'(TMO));
    check("tmo_trace", trace_v, 64'h12370);
    check("tmo_err", 64'(err_flag), 64'd1);
    check("tmo_done", 64'(done_cnt), 64'd0);
    no_ack = 1'b0;

    // zero-wait slave; a second start while busy must be ignored
    begin_test();
    wait_n = 0;
    push_copy(32'h400, 32'h500, 3);
    pulse_start(32'h400, 32'h500, 16'd3);
    step();
    step();
    pulse_start(32'hF00, 32'hE00, 16'd7);
    wait_idle(100, "zw");
    check("zw_err_cleared", 64'(err_flag), 64'd0);
    check("zw_trace", trace_v, 64'h124242460);
    check("zw_words", 64'(words_done), 64'd3);
    check("zw_done", 64'(done_cnt), 64'd1);
    repeat (3) step();
    check("zw_stays_idle", 64'(state), 64'd0);
    check("zw_sb_empty", 64'(exp_q.size()), 64'd0);

    // async reset while a write is waiting for ack
    begin_test();
    wait_n = 3;
    push_copy(32'h800, 32'h900, 2);
    pulse_start(32'h800, 32'h900, 16'd2);
    for (int k = 0; k < 50 && state != 3'd5; k++) step();
    check("rst_mid_reached_wr_wait", 64'(state), 64'd5);
    rst = 1'b1;
    #1;
    check("rst_mid_bus", 64'({cyc, stb, we}), 64'd0);
    check("rst_mid_state", 64'(state), 64'd0);
    check("rst_mid_words", 64'(words_done), 64'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    begin_test();
    wait_n = 0;
    push_copy(32'hA00, 32'hB00, 2);
    pulse_start(32'hA00, 32'hB00, 16'd2);
    wait_idle(100, "post_rst");
    check("post_rst_done", 64'(done_cnt), 64'd1);
    check("post_rst_words", 64'(words_done), 64'd2);
    check("post_rst_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
